// File: rtl/ln_wt_loader.sv
// ln_wt_loader: fetches FP16 LayerNorm weight/bias pairs over a burst-read
// interface, assembles them into TOUT-lane channel groups in an on-chip group
// RAM, and serves one whole group per read to the norm datapath.
// Optional feature macro: LN_RMS_SUPPORT_EN (adds rms_mode; bias forced to 0).
//
// Handshakes: a request or data beat transfers on a rising edge where both
// valid and ready are high; the request fields are held stable while
// rd_req_valid is high and not yet accepted.
module ln_wt_loader #(
    parameter int AXI_DW    = 256,
    parameter int LN_DW     = 16,
    parameter int TOUT      = 32,
    parameter int MAX_CH    = 4096,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              wt_base_addr,
    input  logic [12:0]              ch_num,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_req_valid,
    input  logic                     rd_req_ready,
    output logic [31:0]              rd_req_addr,
    output logic [4:0]               rd_req_len,
    input  logic                     rd_data_valid,
    output logic                     rd_data_ready,
    input  logic [AXI_DW-1:0]        rd_data,
    input  logic                     grp_rd_en,
    input  logic [6:0]               grp_rd_addr,
    output logic                     grp_rd_valid,
    output logic [TOUT*LN_DW-1:0]    grp_wt,
    output logic [TOUT*LN_DW-1:0]    grp_bias
`ifdef LN_RMS_SUPPORT_EN
    ,
    input  logic                     rms_mode
`endif
);

    localparam int NPB   = AXI_DW / (2 * LN_DW);
    localparam int BPG   = TOUT / NPB;
    localparam int DEPTH = MAX_CH / TOUT;
    localparam int GW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(DEPTH * BPG + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int BIW   = (BPG > 1) ? $clog2(BPG) : 1;
    localparam int GDW   = TOUT * LN_DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [12:0]     ch_eff_q, ch_eff_d;
    logic [TW-1:0]   total_q, total_d;
    logic [TW-1:0]   issued_q, issued_d;
    logic [4:0]      burst_left_q, burst_left_d;
    logic [BIW-1:0]  beat_idx_q, beat_idx_d;
    logic [AW-1:0]   grp_idx_q, grp_idx_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [4:0]      req_len_q, req_len_d;
    logic [GDW-1:0]  asm_w_q, asm_w_d, asm_b_q, asm_b_d;
    logic [GDW-1:0]  grp_wt_q, grp_wt_d, grp_bias_q, grp_bias_d;
    logic            grp_vld_q, grp_vld_d;
    logic            rms_q, rms_d;

    logic [12:0]     ch_eff_in;
    logic [GW-1:0]   g_in;
    logic [TW-1:0]   t_in;
    logic [GDW-1:0]  asm_w_nxt, asm_b_nxt, wr_w, wr_b;
    logic            lane_dead;
    logic            ram_we;
    logic            rd_hit;

    logic [GDW-1:0]  wt_ram   [DEPTH];
    logic [GDW-1:0]  bias_ram [DEPTH];

`ifdef LN_RMS_SUPPORT_EN
    logic rms_in;
    assign rms_in = rms_mode;
`else
    logic rms_in;
    assign rms_in = 1'b0;
`endif

    function automatic logic [4:0] burst_len(input logic [TW-1:0] rem);
        if (rem >= TW'(MAX_BURST)) return 5'(MAX_BURST);
        return 5'(rem);
    endfunction

    assign busy          = (state_q == S_REQ) || (state_q == S_DATA);
    assign done          = (state_q == S_DONE);
    assign rd_req_valid  = (state_q == S_REQ);
    assign rd_data_ready = (state_q == S_DATA);
    assign rd_req_addr   = req_addr_q;
    assign rd_req_len    = req_len_q;
    assign grp_rd_valid  = grp_vld_q;
    assign grp_wt        = grp_wt_q;
    assign grp_bias      = grp_bias_q;

    // Load geometry from the start-time inputs.
    always_comb begin
        ch_eff_in = (ch_num > 13'(MAX_CH)) ? 13'(MAX_CH) : ch_num;
        g_in      = GW'((32'(ch_eff_in) + 32'(TOUT) - 32'd1) / 32'(TOUT));
        t_in      = TW'(g_in) * TW'(BPG);
    end

    // Merge the incoming beat into its lane slot and mask padded/bias lanes.
    always_comb begin
        asm_w_nxt = asm_w_q;
        asm_b_nxt = asm_b_q;
        for (int k = 0; k < NPB; k++) begin
            asm_w_nxt[(32'(beat_idx_q) * 32'(NPB) + 32'(k)) * LN_DW +: LN_DW] =
                rd_data[2 * k * LN_DW +: LN_DW];
            asm_b_nxt[(32'(beat_idx_q) * 32'(NPB) + 32'(k)) * LN_DW +: LN_DW] =
                rd_data[(2 * k + 1) * LN_DW +: LN_DW];
        end
        wr_w      = '0;
        wr_b      = '0;
        lane_dead = 1'b0;
        for (int k = 0; k < TOUT; k++) begin
            lane_dead = (32'(grp_idx_q) * 32'(TOUT) + 32'(k)) >= 32'(ch_eff_q);
            wr_w[k * LN_DW +: LN_DW] = lane_dead ? '0 : asm_w_nxt[k * LN_DW +: LN_DW];
            wr_b[k * LN_DW +: LN_DW] = (lane_dead || rms_q) ? '0 : asm_b_nxt[k * LN_DW +: LN_DW];
        end
    end

    // Load FSM: next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        ch_eff_d     = ch_eff_q;
        total_d      = total_q;
        issued_d     = issued_q;
        burst_left_d = burst_left_q;
        beat_idx_d   = beat_idx_q;
        grp_idx_d    = grp_idx_q;
        req_addr_d   = req_addr_q;
        req_len_d    = req_len_q;
        asm_w_d      = asm_w_q;
        asm_b_d      = asm_b_q;
        rms_d        = rms_q;
        ram_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = wt_base_addr;
                    ch_eff_d   = ch_eff_in;
                    total_d    = t_in;
                    issued_d   = '0;
                    beat_idx_d = '0;
                    grp_idx_d  = '0;
                    rms_d      = rms_in;
                    req_addr_d = wt_base_addr;
                    req_len_d  = burst_len(t_in);
                    state_d    = (g_in == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (rd_req_ready) begin
                    burst_left_d = req_len_q;
                    issued_d     = issued_q + TW'(req_len_q);
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (rd_data_valid) begin
                    asm_w_d      = asm_w_nxt;
                    asm_b_d      = asm_b_nxt;
                    burst_left_d = burst_left_q - 5'd1;
                    if (beat_idx_q == BIW'(BPG - 1)) begin
                        ram_we     = rst_n;
                        beat_idx_d = '0;
                        grp_idx_d  = grp_idx_q + AW'(1);
                    end else begin
                        beat_idx_d = beat_idx_q + BIW'(1);
                    end
                    if (burst_left_q == 5'd1) begin
                        if (issued_q < total_q) begin
                            state_d    = S_REQ;
                            req_addr_d = base_q + 32'(issued_q) * 32'(AXI_DW / 8);
                            req_len_d  = burst_len(total_q - issued_q);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Group read port: one-cycle valid, data held afterwards, blocked while loading.
    always_comb begin
        rd_hit     = grp_rd_en && !busy;
        grp_vld_d  = rd_hit;
        grp_wt_d   = rd_hit ? wt_ram[grp_rd_addr]   : grp_wt_q;
        grp_bias_d = rd_hit ? bias_ram[grp_rd_addr] : grp_bias_q;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            ch_eff_q     <= '0;
            total_q      <= '0;
            issued_q     <= '0;
            burst_left_q <= '0;
            beat_idx_q   <= '0;
            grp_idx_q    <= '0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
            asm_w_q      <= '0;
            asm_b_q      <= '0;
            rms_q        <= 1'b0;
            grp_wt_q     <= '0;
            grp_bias_q   <= '0;
            grp_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            ch_eff_q     <= ch_eff_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            burst_left_q <= burst_left_d;
            beat_idx_q   <= beat_idx_d;
            grp_idx_q    <= grp_idx_d;
            req_addr_q   <= req_addr_d;
            req_len_q    <= req_len_d;
            asm_w_q      <= asm_w_d;
            asm_b_q      <= asm_b_d;
            rms_q        <= rms_d;
            grp_wt_q     <= grp_wt_d;
            grp_bias_q   <= grp_bias_d;
            grp_vld_q    <= grp_vld_d;
        end
    end

    // Group RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            wt_ram[grp_idx_q]   <= wr_w;
            bias_ram[grp_idx_q] <= wr_b;
        end
    end

endmodule

// File: tb/tb_ln_wt_loader.sv
// Bench for ln_wt_loader: a behavioural HBM source image, a request scoreboard
// and a group-content reference model derived from channel arithmetic.
module tb_ln_wt_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  wt_base_addr = '0;
    logic [12:0]  ch_num = '0;
    logic         busy, done, rd_req_valid, rd_data_ready, grp_rd_valid;
    logic         rd_req_ready = 1'b0;
    logic [31:0]  rd_req_addr;
    logic [4:0]   rd_req_len;
    logic         rd_data_valid = 1'b0;
    logic [255:0] rd_data = '0;
    logic         grp_rd_en = 1'b0;
    logic [6:0]   grp_rd_addr = '0;
    logic [511:0] grp_wt, grp_bias;
    logic         rms_mode = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0]  src_w [4096];
    logic [15:0]  src_b [4096];
    logic [36:0]  exp_q [$];

    int r_done_cnt, r_done_cyc, r_req_cnt, r_req_err, r_stab_err, r_rd_viol, r_timeout;

    ln_wt_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wt_base_addr(wt_base_addr),
        .ch_num(ch_num), .busy(busy), .done(done), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
        .grp_rd_en(grp_rd_en), .grp_rd_addr(grp_rd_addr), .grp_rd_valid(grp_rd_valid),
        .grp_wt(grp_wt), .grp_bias(grp_bias)
`ifdef LN_RMS_SUPPORT_EN
        , .rms_mode(rms_mode)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ch_eff_of(input int ch);
        return (ch > 4096) ? 4096 : ch;
    endfunction

    function automatic int groups_of(input int ch);
        return (ch_eff_of(ch) + 31) / 32;
    endfunction

    function automatic logic [511:0] exp_w(input int g, input int ch);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 32; k++)
            if (g * 32 + k < ch_eff_of(ch)) v[k*16 +: 16] = src_w[g*32 + k];
        return v;
    endfunction

    function automatic logic [511:0] exp_b(input int g, input int ch, input bit rms);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 32; k++)
            if (g * 32 + k < ch_eff_of(ch) && !rms) v[k*16 +: 16] = src_b[g*32 + k];
        return v;
    endfunction

    // Beat j of the image holds channels 8j..8j+7, weight low half, bias high half.
    function automatic logic [255:0] make_beat(input int j);
        logic [255:0] v;
        v = {8{$urandom}};
        if (j >= 0 && j < 512)
            for (int k = 0; k < 8; k++) begin
                v[k*32 +: 16]      = src_w[j*8 + k];
                v[k*32 + 16 +: 16] = src_b[j*8 + k];
            end
        return v;
    endfunction

    task automatic randomize_src();
        for (int i = 0; i < 4096; i++) begin
            src_w[i] = 16'($urandom);
            src_b[i] = 16'($urandom);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic run_load(input int ch, input logic [31:0] base, input bit stall,
                            input bit poke, input int abort_at);
        int beats_pend, beats_acc, cyc, total;
        logic [31:0] cur_addr, held_addr;
        logic [4:0]  held_len;
        logic        held;
        logic [36:0] e;
        exp_q.delete();
        total = groups_of(ch) * 4;
        for (int i = 0; i < total; i += 16)
            exp_q.push_back({base + 32'(i * 32), 5'(((total - i) > 16) ? 16 : (total - i))});
        r_done_cnt = 0; r_done_cyc = -1; r_req_cnt = 0; r_req_err = 0;
        r_stab_err = 0; r_rd_viol = 0; r_timeout = 0;
        beats_pend = 0; beats_acc = 0; cyc = 0; held = 1'b0; cur_addr = base;
        held_addr = '0; held_len = '0;
        wt_base_addr = base; ch_num = 13'(ch); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (1) begin
            rd_req_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_data_valid = (beats_pend > 0) && (!stall || $urandom_range(0, 1) == 1);
            rd_data       = (beats_pend > 0) ? make_beat(int'((cur_addr - base) >> 5))
                                             : {8{$urandom}};
            grp_rd_en     = poke && (r_done_cyc < 0);
            grp_rd_addr   = 7'($urandom_range(0, 127));
            @(negedge clk);
            if (poke && grp_rd_valid) r_rd_viol++;
            if (held && (!rd_req_valid || rd_req_addr !== held_addr || rd_req_len !== held_len))
                r_stab_err++;
            held = 1'b0;
            if (rd_req_valid) begin
                if (rd_req_ready) begin
                    r_req_cnt++;
                    if (exp_q.size() == 0) r_req_err++;
                    else begin
                        e = exp_q.pop_front();
                        if ({rd_req_addr, rd_req_len} !== e) r_req_err++;
                    end
                    beats_pend = int'(rd_req_len);
                    cur_addr   = rd_req_addr;
                end else begin
                    held = 1'b1; held_addr = rd_req_addr; held_len = rd_req_len;
                end
            end
            if (rd_data_valid && rd_data_ready) begin
                beats_pend--; beats_acc++; cur_addr += 32;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
                grp_rd_en = 1'b0;
            end
            if (abort_at >= 0 && beats_acc == abort_at) break;
            if (r_done_cyc >= 0 && cyc >= r_done_cyc + 2) break;
            if (cyc >= 5000) begin r_timeout = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        rd_req_ready = 1'b0; rd_data_valid = 1'b0; grp_rd_en = 1'b0;
        if (abort_at < 0) begin @(posedge clk); #1; end
    endtask

    task automatic read_group(input int g, output logic vld, output logic [511:0] w,
                              output logic [511:0] b);
        grp_rd_addr = 7'(g); grp_rd_en = 1'b1;
        @(posedge clk); #1 grp_rd_en = 1'b0;
        @(negedge clk);
        vld = grp_rd_valid; w = grp_wt; b = grp_bias;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks += 9;
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (rd_req_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", rd_req_valid); end
        if (rd_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b expected 0", rd_data_ready); end
        if (grp_rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_grp_valid: got %b expected 0", grp_rd_valid); end
        if (rd_req_addr !== 32'h0)  begin n_fail++; $display("FAIL reset_req_addr: got %h expected 0", rd_req_addr); end
        if (rd_req_len !== 5'h0)    begin n_fail++; $display("FAIL reset_req_len: got %h expected 0", rd_req_len); end
        if (grp_wt !== '0)          begin n_fail++; $display("FAIL reset_grp_wt: got %h expected 0", grp_wt); end
        if (grp_bias !== '0)        begin n_fail++; $display("FAIL reset_grp_bias: got %h expected 0", grp_bias); end
    endtask

    task automatic test_full_1024();
        logic vld; logic [511:0] w, b;
        randomize_src();
        run_load(1024, 32'h0100_0000, 1'b0, 1'b0, -1);
        n_checks += 5;
        if (r_timeout != 0)  begin n_fail++; $display("FAIL full_timeout: got %0d expected 0", r_timeout); end
        if (r_req_cnt != 8)  begin n_fail++; $display("FAIL full_req_cnt: got %0d expected 8", r_req_cnt); end
        if (r_req_err != 0 || exp_q.size() != 0)
                             begin n_fail++; $display("FAIL full_req_fields: got %0d bad, %0d missing expected 0", r_req_err, exp_q.size()); end
        if (r_done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d expected 1", r_done_cnt); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL full_busy_after: got %b expected 0", busy); end
        for (int g = 0; g < 32; g++) begin
            read_group(g, vld, w, b);
            n_checks += 3;
            if (vld !== 1'b1)       begin n_fail++; $display("FAIL full_g%0d_valid: got %b expected 1", g, vld); end
            if (w !== exp_w(g, 1024)) begin n_fail++; $display("FAIL full_g%0d_wt: got %h expected %h", g, w, exp_w(g, 1024)); end
            if (b !== exp_b(g, 1024, 1'b0)) begin n_fail++; $display("FAIL full_g%0d_bias: got %h expected %h", g, b, exp_b(g, 1024, 1'b0)); end
        end
    endtask

    task automatic test_partial_40();
        logic vld; logic [511:0] w, b;
        randomize_src();
        run_load(40, 32'h2000_0040, 1'b0, 1'b0, -1);
        n_checks += 3;
        if (r_req_cnt != 1)  begin n_fail++; $display("FAIL p40_req_cnt: got %0d expected 1", r_req_cnt); end
        if (r_req_err != 0 || exp_q.size() != 0)
                             begin n_fail++; $display("FAIL p40_req_fields: got %0d bad expected 0", r_req_err); end
        if (r_done_cnt != 1) begin n_fail++; $display("FAIL p40_done_cnt: got %0d expected 1", r_done_cnt); end
        for (int g = 0; g < 2; g++) begin
            read_group(g, vld, w, b);
            n_checks += 2;
            if (w !== exp_w(g, 40)) begin n_fail++; $display("FAIL p40_g%0d_wt: got %h expected %h", g, w, exp_w(g, 40)); end
            if (b !== exp_b(g, 40, 1'b0)) begin n_fail++; $display("FAIL p40_g%0d_bias: got %h expected %h", g, b, exp_b(g, 40, 1'b0)); end
        end
    endtask

    task automatic test_zero_ch();
        run_load(0, 32'h0000_1000, 1'b0, 1'b0, -1);
        n_checks += 3;
        if (r_req_cnt != 0)  begin n_fail++; $display("FAIL zero_req_cnt: got %0d expected 0", r_req_cnt); end
        if (r_done_cyc != 0) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 0", r_done_cyc); end
        if (r_done_cnt != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d expected 1", r_done_cnt); end
    endtask

    task automatic test_stall_256();
        logic vld; logic [511:0] w, b;
        randomize_src();
        run_load(256, 32'h0300_0000 + 32'($urandom_range(0, 1023)) * 32, 1'b1, 1'b0, -1);
        n_checks += 4;
        if (r_timeout != 0)  begin n_fail++; $display("FAIL stall_timeout: got %0d expected 0", r_timeout); end
        if (r_req_cnt != 2 || r_req_err != 0)
                             begin n_fail++; $display("FAIL stall_reqs: got %0d reqs %0d bad expected 2 reqs 0 bad", r_req_cnt, r_req_err); end
        if (r_stab_err != 0) begin n_fail++; $display("FAIL stall_req_stable: got %0d changes expected 0", r_stab_err); end
        if (r_done_cnt != 1) begin n_fail++; $display("FAIL stall_done_cnt: got %0d expected 1", r_done_cnt); end
        for (int g = 0; g < 8; g++) begin
            read_group(g, vld, w, b);
            n_checks += 2;
            if (w !== exp_w(g, 256)) begin n_fail++; $display("FAIL stall_g%0d_wt: got %h expected %h", g, w, exp_w(g, 256)); end
            if (b !== exp_b(g, 256, 1'b0)) begin n_fail++; $display("FAIL stall_g%0d_bias: got %h expected %h", g, b, exp_b(g, 256, 1'b0)); end
        end
    endtask

    task automatic test_reset_midload();
        logic vld; logic [511:0] w, b;
        randomize_src();
        run_load(1024, 32'h0400_0000, 1'b0, 1'b0, 20);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks += 8;
        if (r_done_cnt != 0)        begin n_fail++; $display("FAIL abort_done_seen: got %0d expected 0", r_done_cnt); end
        if (busy !== 1'b0)          begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (done !== 1'b0)          begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        if (rd_req_valid !== 1'b0)  begin n_fail++; $display("FAIL abort_req_valid: got %b expected 0", rd_req_valid); end
        if (rd_data_ready !== 1'b0) begin n_fail++; $display("FAIL abort_data_ready: got %b expected 0", rd_data_ready); end
        if (rd_req_addr !== 32'h0 || rd_req_len !== 5'h0)
                                    begin n_fail++; $display("FAIL abort_req_fields: got %h/%h expected 0/0", rd_req_addr, rd_req_len); end
        if (grp_wt !== '0)          begin n_fail++; $display("FAIL abort_grp_wt: got %h expected 0", grp_wt); end
        if (grp_bias !== '0)        begin n_fail++; $display("FAIL abort_grp_bias: got %h expected 0", grp_bias); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        randomize_src();
        run_load(64, 32'h0500_0000, 1'b0, 1'b0, -1);
        n_checks += 1;
        if (r_done_cnt != 1 || r_req_cnt != 1 || r_req_err != 0)
            begin n_fail++; $display("FAIL reload_run: got done %0d reqs %0d bad %0d expected 1 1 0", r_done_cnt, r_req_cnt, r_req_err); end
        for (int g = 0; g < 2; g++) begin
            read_group(g, vld, w, b);
            n_checks += 2;
            if (w !== exp_w(g, 64)) begin n_fail++; $display("FAIL reload_g%0d_wt: got %h expected %h", g, w, exp_w(g, 64)); end
            if (b !== exp_b(g, 64, 1'b0)) begin n_fail++; $display("FAIL reload_g%0d_bias: got %h expected %h", g, b, exp_b(g, 64, 1'b0)); end
        end
    endtask

    task automatic test_grp_read();
        logic [511:0] w0;
        randomize_src();
        run_load(256, 32'h0600_0000, 1'b0, 1'b1, -1);
        n_checks += 1;
        if (r_rd_viol != 0) begin n_fail++; $display("FAIL busy_read_valid: got %0d valid cycles expected 0", r_rd_viol); end
        grp_rd_addr = 7'd3; grp_rd_en = 1'b1;
        @(posedge clk); #1 grp_rd_en = 1'b0; grp_rd_addr = 7'd6;
        @(negedge clk);
        w0 = grp_wt;
        n_checks += 2;
        if (grp_rd_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid_n1: got %b expected 1", grp_rd_valid); end
        if (w0 !== exp_w(3, 256))  begin n_fail++; $display("FAIL read_data_n1: got %h expected %h", w0, exp_w(3, 256)); end
        @(negedge clk);
        n_checks += 2;
        if (grp_rd_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_n2: got %b expected 0", grp_rd_valid); end
        if (grp_wt !== exp_w(3, 256) || grp_bias !== exp_b(3, 256, 1'b0))
            begin n_fail++; $display("FAIL read_hold: got %h expected %h", grp_wt, exp_w(3, 256)); end
        @(posedge clk); #1;
    endtask

`ifdef LN_RMS_SUPPORT_EN
    task automatic test_rms();
        logic vld; logic [511:0] w, b;
        randomize_src();
        rms_mode = 1'b1;
        run_load(96, 32'h0700_0000, 1'b0, 1'b0, -1);
        rms_mode = 1'b0;
        for (int g = 0; g < 3; g++) begin
            read_group(g, vld, w, b);
            n_checks += 2;
            if (w !== exp_w(g, 96)) begin n_fail++; $display("FAIL rms_g%0d_wt: got %h expected %h", g, w, exp_w(g, 96)); end
            if (b !== exp_b(g, 96, 1'b1)) begin n_fail++; $display("FAIL rms_g%0d_bias: got %h expected 0", g, b); end
        end
    endtask
`endif

    // Test sequence and final report
    initial begin
        test_reset();
        test_full_1024();
        test_partial_40();
        test_zero_ch();
        test_stall_256();
        test_reset_midload();
        test_grp_read();
`ifdef LN_RMS_SUPPORT_EN
        test_rms();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ln_wt_loader.md
Name: ln_wt_loader

Overview:
- Upstream feeder of the LayerNorm/RMSNorm core.
- Fetches per-channel LN weight/bias pairs (FP16, packed into AXI beats) from HBM through a simple burst-read request/data interface.
- Assembles them into Tout-lane channel groups in an on-chip group RAM.
- Serves one full group per read to the norm datapath, indexed by channel-group number.

Parameters:
AXI_DW, 256, data beat width in bits
LN_DW, 16, width of one weight or bias element (FP16)
TOUT, 32, channel lanes per group
MAX_CH, 4096, maximum channels; group RAM depth = MAX_CH/TOUT
MAX_BURST, 16, maximum beats per read request
Derived: NPB = AXI_DW/(2*LN_DW) = 8 pairs per beat; BPG = TOUT/NPB = 4 beats per group; TOUT must be a multiple of NPB.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begin load
wt_base_addr  in  32  byte address of first beat
ch_num  in  13  channel count (CHout)
busy  out  1  load in progress
done  out  1  one-cycle pulse, load complete
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  request accepted
rd_req_addr  out  32  request byte address
rd_req_len  out  5  beats in request (1..MAX_BURST)
rd_data_valid  in  1  beat valid
rd_data_ready  out  1  loader accepts beat
rd_data  in  AXI_DW  beat payload
grp_rd_en  in  1  group read strobe
grp_rd_addr  in  7  group index
grp_rd_valid  out  1  group data valid
grp_wt  out  TOUT*LN_DW  lane weights; lane k at [k*LN_DW +: LN_DW]
grp_bias  out  TOUT*LN_DW  lane biases, same lane order

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE. busy, done, rd_req_valid, rd_data_ready, grp_rd_valid = 0. rd_req_addr, rd_req_len, grp_wt, grp_bias = 0. Group RAM contents are not cleared.
- Beat packing: pair k occupies bits [2k*LN_DW +: 2*LN_DW]; the low half is weight, the high half is bias. Beat j of group g holds channels g*TOUT + j*NPB + k.
- Load geometry: ch_eff = min(ch_num, MAX_CH); G = ceil(ch_eff/TOUT); total beats T = G*BPG. Memory is padded to G*TOUT channels.
- States:
  - IDLE: start while in IDLE latches base/ch_num, sets busy, and moves to REQ. If G=0, it goes to DONE instead.
  - REQ: rd_req_valid=1; len = min(MAX_BURST, beats remaining); addr = base + beats_issued*AXI_DW/8. On rd_req_valid & rd_req_ready, move to DATA. The request fields are stable while valid is high.
  - DATA: rd_data_ready=1. Each accepted beat goes into the lane slot selected by the beat-in-group counter. When the BPG-th beat of a group is accepted, the assembled group is written to RAM[g] on that same edge. Lanes with channel index >= ch_eff are forced to weight=0, bias=0. When the burst count is exhausted, go to REQ if beats remain, else DONE. Only one request is outstanding at a time.
  - DONE: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- start while busy is ignored.
- Reset mid-load aborts immediately. No done pulse is produced, and partially written RAM contents are undefined.
- Group read port:
  - grp_rd_en sampled at edge N gives grp_wt/grp_bias and grp_rd_valid=1 during cycle N+1 only. Outputs hold their value afterwards.
  - While busy=1, grp_rd_en is ignored (grp_rd_valid stays 0).
  - grp_rd_addr >= G returns stale RAM contents.
- Data beats arriving while rd_data_ready=0 stay pending at the source; the loader never drops a beat.

Optional Feature:
- Macro LN_RMS_SUPPORT_EN.
- Defined: adds input rms_mode (1 bit), latched at start. When it is 1, all bias lanes are written as 0 regardless of beat content, giving RMSNorm with no bias term. Fetch geometry is unchanged.
- Undefined: there is no rms_mode port, and bias is always taken from the beat.

Test Plan:
- ch_num=1024, base=0x0100_0000, request always ready, no data gaps -> 8 requests, each len=16, at addresses 0x0100_0000 + n*0x200. 32 groups written. done asserted once. A read of group 5 returns lane k weight/bias equal to channel 160+k from the source image.
- ch_num=40 -> G=2, 8 beats, a single request with len=8. In group 1, lanes 0-7 carry channels 32-39 and lanes 8-31 read back as 0/0.
- ch_num=0 -> no rd_req_valid. done pulses on the cycle after start.
- Random rd_req_ready stalls and rd_data_valid gaps (roughly 50%), ch_num=256 -> RAM contents identical to the no-stall run; request fields stable while stalled.
- rst_n=0 asserted after 20 beats of a 1024-channel load -> all outputs 0 the next cycle, no done pulse. A subsequent start with ch_num=64 completes normally with correct groups 0 and 1.
- grp_rd_en pulsed during busy -> grp_rd_valid stays 0. After done, grp_rd_en at edge N -> grp_rd_valid high only in cycle N+1. With LN_RMS_SUPPORT_EN defined and rms_mode=1, all grp_bias lanes read 0.
